// File: rtl/key_repeat_pkg.sv
// ============================================================================
// Module      : key_repeat_pkg
// Description : Shared types and cycle-count derivation for the key_repeat
//               press-event generator (state encoding, simulation scaling).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package key_repeat_pkg;

  // Per-key FSM encoding; WAIT_RELEASE is the reset state so a key held
  // through reset never produces a press event.
  typedef enum logic [1:0] {
    WAIT_RELEASE = 2'd0,
    IDLE         = 2'd1,
    HOLD         = 2'd2,
    REPEAT       = 2'd3
  } state_t;

  // Shortened timings used when SIMULATION=1, shared with the debounce and
  // clock-divider blocks so that all timers scale together.
  localparam int unsigned SIM_HOLD_CYCLES   = 200;
  localparam int unsigned SIM_REPEAT_CYCLES = 50;

  // Width of the per-hold press counter reported to the controller.
  localparam int unsigned PULSE_COUNT_W = 8;

  // Milliseconds to clock cycles; divide first to stay within 32 bits.
  function automatic int unsigned ms_to_cycles(input int unsigned clk_freq,
                                               input int unsigned ms);
    return (clk_freq / 1000) * ms;
  endfunction

  // Select the simulation constant or the real-time derived cycle count.
  function automatic int unsigned scaled_cycles(input bit          sim,
                                                input int unsigned sim_cycles,
                                                input int unsigned clk_freq,
                                                input int unsigned ms);
    return sim ? sim_cycles : ms_to_cycles(clk_freq, ms);
  endfunction

  function automatic int unsigned max_u(input int unsigned a,
                                        input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/key_repeat_if.sv
// ============================================================================
// Module      : key_repeat_if
// Description : Key level / controller enable in, press-event outputs back to
//               the clock controller. master = controller side, slave = DUT.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface key_repeat_if;
  import key_repeat_pkg::*;

  logic                     key_n;
  logic                     repeat_en;
  logic                     press_pulse;
  logic                     release_pulse;
  logic                     long_press;
  logic [PULSE_COUNT_W-1:0] pulse_count;

  modport master (
    output key_n,
    output repeat_en,
    input  press_pulse,
    input  release_pulse,
    input  long_press,
    input  pulse_count
  );

  modport slave (
    input  key_n,
    input  repeat_en,
    output press_pulse,
    output release_pulse,
    output long_press,
    output pulse_count
  );

endinterface

`default_nettype wire

// File: rtl/key_repeat.sv
// ============================================================================
// Module      : key_repeat
// Description : Turns a debounced active-low key level into one-cycle press /
//               release pulses, with optional auto-repeat after a long hold,
//               a long-press level and a saturating per-hold pulse count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_repeat
  import key_repeat_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned HOLD_MS    = 500,
  parameter int unsigned REPEAT_MS  = 100,
  parameter int unsigned SIMULATION = 0
) (
  input  wire logic    clk,
  input  wire logic    rst,
  key_repeat_if.slave  kif
);

  localparam int unsigned HOLD_CYCLES =
    scaled_cycles(SIMULATION != 0, SIM_HOLD_CYCLES, CLK_FREQ, HOLD_MS);
  localparam int unsigned REPEAT_CYCLES =
    scaled_cycles(SIMULATION != 0, SIM_REPEAT_CYCLES, CLK_FREQ, REPEAT_MS);
  localparam int unsigned CNT_RAW_W = $clog2(max_u(HOLD_CYCLES, REPEAT_CYCLES));
  localparam int unsigned CNT_W     = (CNT_RAW_W < 1) ? 1 : CNT_RAW_W;

  localparam logic [CNT_W-1:0]         HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]         REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0]         CNT_ZERO    = '0;
  localparam logic [CNT_W-1:0]         CNT_ONE     = CNT_W'(1);
  localparam logic [PULSE_COUNT_W-1:0] PCNT_ONE    = PULSE_COUNT_W'(1);
  localparam logic [PULSE_COUNT_W-1:0] PCNT_MAX    = '1;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         counter_q, counter_d;
  logic                     press_pulse_q, press_pulse_d;
  logic                     release_pulse_q, release_pulse_d;
  logic                     long_press_q, long_press_d;
  logic [PULSE_COUNT_W-1:0] pulse_count_q, pulse_count_d;

  // State, timer and all outputs are registered; reset is asynchronous.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= WAIT_RELEASE;
      counter_q       <= '0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
      long_press_q    <= 1'b0;
      pulse_count_q   <= '0;
    end else begin
      state_q         <= state_d;
      counter_q       <= counter_d;
      press_pulse_q   <= press_pulse_d;
      release_pulse_q <= release_pulse_d;
      long_press_q    <= long_press_d;
      pulse_count_q   <= pulse_count_d;
    end
  end

  // Next-state and output logic; release is checked first in every held
  // state so it always wins over a coincident repeat terminal count.
  always_comb begin
    state_d         = state_q;
    counter_d       = counter_q;
    press_pulse_d   = 1'b0;
    release_pulse_d = 1'b0;
    long_press_d    = long_press_q;
    pulse_count_d   = pulse_count_q;

    case (state_q)
      WAIT_RELEASE: begin
        if (kif.key_n) begin
          state_d = IDLE;
        end
      end

      IDLE: begin
        if (!kif.key_n) begin
          state_d       = HOLD;
          press_pulse_d = 1'b1;
          pulse_count_d = PCNT_ONE;
          counter_d     = CNT_ZERO;
        end
      end

      HOLD: begin
        if (kif.key_n) begin
          state_d         = IDLE;
          release_pulse_d = 1'b1;
          long_press_d    = 1'b0;
          counter_d       = CNT_ZERO;
        end else if (long_press_q) begin
          // Frozen hold: wait for the controller to permit repeating.
          if (kif.repeat_en) begin
            state_d   = REPEAT;
            counter_d = CNT_ZERO;
          end
        end else if (counter_q == HOLD_LAST) begin
          long_press_d = 1'b1;
          counter_d    = CNT_ZERO;
          if (kif.repeat_en) begin
            state_d = REPEAT;
          end
        end else begin
          counter_d = counter_q + CNT_ONE;
        end
      end

      REPEAT: begin
        if (kif.key_n) begin
          state_d         = IDLE;
          release_pulse_d = 1'b1;
          long_press_d    = 1'b0;
          counter_d       = CNT_ZERO;
        end else if (!kif.repeat_en) begin
          state_d   = HOLD;
          counter_d = CNT_ZERO;
        end else if (counter_q == REPEAT_LAST) begin
          press_pulse_d = 1'b1;
          counter_d     = CNT_ZERO;
          if (pulse_count_q != PCNT_MAX) begin
            pulse_count_d = pulse_count_q + PCNT_ONE;
          end
        end else begin
          counter_d = counter_q + CNT_ONE;
        end
      end

      default: begin
        state_d = WAIT_RELEASE;
      end
    endcase
  end

  assign kif.press_pulse   = press_pulse_q;
  assign kif.release_pulse = release_pulse_q;
  assign kif.long_press    = long_press_q;
  assign kif.pulse_count   = pulse_count_q;

endmodule

`default_nettype wire

// File: tb/tb_key_repeat.sv
// ============================================================================
// Module      : tb_key_repeat
// Description : Directed self-checking bench for key_repeat (SIMULATION=1,
//               HOLD=200 cycles, REPEAT=50 cycles, 20 ns clock).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_key_repeat;

  logic clk;
  logic rst;

  key_repeat_if kif();

  key_repeat #(
    .CLK_FREQ   (50_000_000),
    .HOLD_MS    (500),
    .REPEAT_MS  (100),
    .SIMULATION (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .kif (kif)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Cycle bookkeeping: offsets are relative to t0, the cycle in which the
  // press pulse of the current scenario is expected (offset 0).
  int cyc     = 0;
  int t0      = 0;
  int overlap = 0;
  bit long_prev = 1'b0;
  int press_log[$];
  int release_log[$];
  int long_rise_log[$];
  int long_fall_log[$];

  // Advance one clock and sample outputs 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (kif.press_pulse === 1'b1)   press_log.push_back(cyc - t0);
    if (kif.release_pulse === 1'b1) release_log.push_back(cyc - t0);
    if (kif.press_pulse === 1'b1 && kif.release_pulse === 1'b1) overlap++;
    if (kif.long_press === 1'b1 && !long_prev) long_rise_log.push_back(cyc - t0);
    if (kif.long_press !== 1'b1 && long_prev)  long_fall_log.push_back(cyc - t0);
    long_prev = (kif.long_press === 1'b1);
  endtask

  // Start a scenario: the next step() is offset 0.
  task automatic begin_scenario();
    press_log.delete();
    release_log.delete();
    long_rise_log.delete();
    long_fall_log.delete();
    t0 = cyc + 1;
  endtask

  // Hold key_n low for n_low sampled edges, release, and let it settle.
  task automatic press_for(input int n_low);
    kif.key_n = 1'b0;
    for (int i = 0; i < n_low; i++) step();
    kif.key_n = 1'b1;
    for (int i = 0; i < 5; i++) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    kif.key_n = 1'b1;
    kif.repeat_en = 1'b0;
    for (int i = 0; i < 3; i++) step();
    n_tests++;
    if (kif.press_pulse !== 1'b0 || kif.release_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_pulses: press=%b release=%b, want 0 0", kif.press_pulse, kif.release_pulse);
    end
    n_tests++;
    if (kif.long_press !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_long: got %b want 0", kif.long_press);
    end
    n_tests++;
    if (kif.pulse_count !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_count: got %0d want 0", kif.pulse_count);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step();
    n_tests++;
    if (kif.press_pulse !== 1'b0 || kif.pulse_count !== 8'd0) begin
      n_fail++;
      $display("FAIL post_reset_idle: press=%b count=%0d, want 0 0", kif.press_pulse, kif.pulse_count);
    end
  endtask

  task automatic test_short_press();
    kif.repeat_en = 1'b1;
    begin_scenario();
    press_for(100);
    n_tests++;
    if (press_log.size() != 1 || press_log[0] != 0) begin
      n_fail++;
      $display("FAIL short_press: got %0d pulses first@%0d, want 1 pulse @0",
               press_log.size(), (press_log.size() > 0) ? press_log[0] : -1);
    end
    n_tests++;
    if (release_log.size() != 1 || release_log[0] != 100) begin
      n_fail++;
      $display("FAIL short_release: got %0d pulses first@%0d, want 1 pulse @100",
               release_log.size(), (release_log.size() > 0) ? release_log[0] : -1);
    end
    n_tests++;
    if (long_rise_log.size() != 0) begin
      n_fail++;
      $display("FAIL short_long: long_press rose %0d times, want 0", long_rise_log.size());
    end
    n_tests++;
    if (kif.pulse_count !== 8'd1) begin
      n_fail++;
      $display("FAIL short_count: got %0d want 1", kif.pulse_count);
    end
  endtask

  task automatic test_auto_repeat();
    int exp_p[4] = '{0, 250, 300, 350};
    int got;
    kif.repeat_en = 1'b1;
    begin_scenario();
    press_for(400);
    n_tests++;
    if (press_log.size() != 4) begin
      n_fail++;
      $display("FAIL auto_press_num: got %0d want 4", press_log.size());
    end
    for (int i = 0; i < 4; i++) begin
      got = (i < press_log.size()) ? press_log[i] : -1;
      n_tests++;
      if (got != exp_p[i]) begin
        n_fail++;
        $display("FAIL auto_press_off[%0d]: got %0d want %0d", i, got, exp_p[i]);
      end
    end
    n_tests++;
    if (long_rise_log.size() != 1 || long_rise_log[0] != 200 ||
        long_fall_log.size() != 1 || long_fall_log[0] != 400) begin
      n_fail++;
      $display("FAIL auto_long: rise@%0d fall@%0d, want rise@200 fall@400",
               (long_rise_log.size() > 0) ? long_rise_log[0] : -1,
               (long_fall_log.size() > 0) ? long_fall_log[0] : -1);
    end
    n_tests++;
    if (release_log.size() != 1 || release_log[0] != 400) begin
      n_fail++;
      $display("FAIL auto_release: got %0d pulses first@%0d, want 1 @400",
               release_log.size(), (release_log.size() > 0) ? release_log[0] : -1);
    end
    n_tests++;
    if (kif.pulse_count !== 8'd4) begin
      n_fail++;
      $display("FAIL auto_count: got %0d want 4", kif.pulse_count);
    end
  endtask

  task automatic test_repeat_disabled();
    kif.repeat_en = 1'b0;
    begin_scenario();
    kif.key_n = 1'b0;
    for (int i = 0; i < 400; i++) begin
      step();
      if (i == 299) kif.repeat_en = 1'b1;
      if (i == 300) begin
        n_tests++;
        if (kif.pulse_count !== 8'd1 || kif.long_press !== 1'b1) begin
          n_fail++;
          $display("FAIL dis_frozen: count=%0d long=%b, want 1 1", kif.pulse_count, kif.long_press);
        end
      end
    end
    kif.key_n = 1'b1;
    for (int i = 0; i < 5; i++) step();
    n_tests++;
    if (press_log.size() != 2 || press_log[0] != 0 || press_log[1] != 350) begin
      n_fail++;
      $display("FAIL dis_press: got %0d pulses second@%0d, want 2 pulses @0,@350",
               press_log.size(), (press_log.size() > 1) ? press_log[1] : -1);
    end
    n_tests++;
    if (long_rise_log.size() != 1 || long_rise_log[0] != 200) begin
      n_fail++;
      $display("FAIL dis_long: rise@%0d, want 200", (long_rise_log.size() > 0) ? long_rise_log[0] : -1);
    end
    n_tests++;
    if (kif.pulse_count !== 8'd2) begin
      n_fail++;
      $display("FAIL dis_count: got %0d want 2", kif.pulse_count);
    end
  endtask

  task automatic test_release_collision();
    kif.repeat_en = 1'b1;
    begin_scenario();
    press_for(300);
    n_tests++;
    if (press_log.size() != 2 || press_log[1] != 250) begin
      n_fail++;
      $display("FAIL coll_press: got %0d pulses last@%0d, want 2 pulses last@250",
               press_log.size(), (press_log.size() > 0) ? press_log[press_log.size()-1] : -1);
    end
    n_tests++;
    if (release_log.size() != 1 || release_log[0] != 300) begin
      n_fail++;
      $display("FAIL coll_release: got %0d pulses first@%0d, want 1 @300",
               release_log.size(), (release_log.size() > 0) ? release_log[0] : -1);
    end
    n_tests++;
    if (kif.pulse_count !== 8'd2) begin
      n_fail++;
      $display("FAIL coll_count: got %0d want 2", kif.pulse_count);
    end
  endtask

  task automatic test_reset_mid_hold();
    kif.repeat_en = 1'b1;
    begin_scenario();
    kif.key_n = 1'b0;
    for (int i = 0; i <= 220; i++) step();
    rst = 1'b1;
    #1;
    n_tests++;
    if (kif.long_press !== 1'b0 || kif.pulse_count !== 8'd0 ||
        kif.press_pulse !== 1'b0 || kif.release_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_async: long=%b count=%0d press=%b release=%b, want all 0",
               kif.long_press, kif.pulse_count, kif.press_pulse, kif.release_pulse);
    end
    step();
    step();
    rst = 1'b0;
    begin_scenario();
    for (int i = 0; i < 100; i++) step();
    n_tests++;
    if (press_log.size() != 0 || kif.pulse_count !== 8'd0) begin
      n_fail++;
      $display("FAIL rst_held_key: %0d pulses count=%0d, want 0 pulses count 0",
               press_log.size(), kif.pulse_count);
    end
    kif.key_n = 1'b1;
    step();
    begin_scenario();
    press_for(20);
    n_tests++;
    if (press_log.size() != 1 || press_log[0] != 0 || kif.pulse_count !== 8'd1) begin
      n_fail++;
      $display("FAIL rst_repress: %0d pulses count=%0d, want 1 pulse @0 count 1",
               press_log.size(), kif.pulse_count);
    end
  endtask

  task automatic test_saturation();
    kif.repeat_en = 1'b1;
    begin_scenario();
    press_for(200 + 50 * 260);
    n_tests++;
    if (press_log.size() != 260) begin
      n_fail++;
      $display("FAIL sat_press_num: got %0d want 260", press_log.size());
    end
    n_tests++;
    if (press_log.size() == 0 || press_log[press_log.size()-1] != 13150) begin
      n_fail++;
      $display("FAIL sat_last_press: got %0d want 13150",
               (press_log.size() > 0) ? press_log[press_log.size()-1] : -1);
    end
    n_tests++;
    if (kif.pulse_count !== 8'd255) begin
      n_fail++;
      $display("FAIL sat_count: got %0d want 255", kif.pulse_count);
    end
  endtask

  task automatic test_exclusive();
    n_tests++;
    if (overlap != 0) begin
      n_fail++;
      $display("FAIL press_release_overlap: got %0d cycles want 0", overlap);
    end
  endtask

  initial begin
    rst = 1'b1;
    kif.key_n = 1'b1;
    kif.repeat_en = 1'b0;
    test_reset();
    test_short_press();
    test_auto_repeat();
    test_repeat_disabled();
    test_release_collision();
    test_reset_mid_hold();
    test_saturation();
    test_exclusive();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
